// File: rtl/pipe_reg_ctrl.sv
// rtl/pipe_reg_ctrl.sv - pipeline register load/flush sequencer with memory-wait FSM
// Optional macro PIPE_CTRL_PERF_EN adds stall and flush performance counters.
module pipe_reg_ctrl #(
  parameter int STAGES   = 4,
  parameter int MEM_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  output logic [STAGES:0]   load_o,
  output logic [STAGES-1:0] flush_o,
  output logic              mem_stall_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic {RUN, MSTALL} state_t;

  localparam logic [3:0] WAIT_M1 = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       stall_req;
  logic       use_prio;
  logic       lu_hold;
  logic       br_flush;

  assign stall_req = mem_req_i && (MEM_WAIT != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    load_o      = '1;
    flush_o     = '0;
    mem_stall_o = 1'b0;
    use_prio    = 1'b0;
    lu_hold     = 1'b0;
    br_flush    = 1'b0;

    case (state)
      RUN: begin
        if (stall_req) begin
          load_o      = '0;
          mem_stall_o = 1'b1;
          state_n     = MSTALL;
          cnt_n       = WAIT_M1;
        end else begin
          use_prio = 1'b1;
        end
      end
      MSTALL: begin
        if (cnt != 4'd0) begin
          load_o      = '0;
          mem_stall_o = 1'b1;
          cnt_n       = cnt - 4'd1;
        end else begin
          // release cycle: mem_req_i still names the completing access
          use_prio = 1'b1;
          state_n  = RUN;
        end
      end
      default: state_n = RUN;
    endcase

    // branch wins: the load-use dependent is on the wrong path anyway
    if (use_prio) begin
      if (branch_taken_i) begin
        flush_o[0] = 1'b1;
        flush_o[1] = 1'b1;
        br_flush   = 1'b1;
      end else if (load_use_i) begin
        load_o[0]  = 1'b0;
        load_o[1]  = 1'b0;
        flush_o[1] = 1'b1;
        lu_hold    = 1'b1;
      end
    end

    if (rst) begin
      load_o      = '0;
      flush_o     = '1;
      mem_stall_o = 1'b0;
      lu_hold     = 1'b0;
      br_flush    = 1'b0;
      state_n     = RUN;
      cnt_n       = 4'd0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (mem_stall_o || lu_hold) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (br_flush)               flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lu_hold ^ br_flush;
`endif

endmodule

// File: doc/pipe_reg_ctrl.md
Name: pipe_reg_ctrl

Overview:
- Central stall/flush sequencer for the pipeline's load-enabled n-bit registers: the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Drives each register's load enable and a per-stage flush (bubble insert) from three sources: the hazard unit's load-use flag, the EX-stage branch-taken flag, and a fixed-latency single-port data-memory wait sequencer.
- Sits between the hazard/branch logic and the datapath registers; contains the only pipeline-control state machine.

Parameters:
- STAGES, 4, number of pipeline registers controlled (IF/ID = index 0 upward); legal range 2..8.
- MEM_WAIT, 2, stall cycles inserted per data-memory access; 0 means no stall; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_use_i  input  1  hazard unit: instruction in ID depends on a load in EX.
- branch_taken_i  input  1  branch/jump in EX resolved taken this cycle.
- mem_req_i  input  1  instruction in EX/MEM is a load/store needing data memory.
- load_o  output  STAGES+1  bit 0 = PC load, bit k+1 = load of pipeline register k.
- flush_o  output  STAGES  bit k = register k captures NOP/zero at this edge (only meaningful with load_o[k+1]=1).
- mem_stall_o  output  1  high on every memory stall cycle.

Behaviour:
- Outputs are combinational from state and inputs (Mealy), so a stall takes effect in the same cycle it is detected.
- Registered state: two-state FSM {RUN, MSTALL} and a 4-bit down-counter cnt.
- Reset: while rst=1, load_o=0, flush_o=all ones, mem_stall_o=0. At the edge, state<=RUN and cnt<=0. Reset mid-stall aborts the stall the same way.

Output priority in RUN, highest first:
- Memory stall: mem_req_i=1 and MEM_WAIT>0.
  - load_o=0, flush_o=0, mem_stall_o=1.
  - Next state MSTALL, cnt<=MEM_WAIT-1.
  - branch_taken_i and load_use_i are ignored; frozen registers re-present them after release.
- Branch taken: load_o=all ones, flush_o[0]=1, flush_o[1]=1, other flush bits 0.
- Load-use: load_o[0]=0 and load_o[1]=0 (PC and IF/ID hold), all other loads 1, flush_o[1]=1 (bubble into ID/EX).
- Otherwise: load_o=all ones, flush_o=0.
- Branch beats load-use because the dependent instruction is on the wrong path.

MSTALL state:
- cnt!=0: load_o=0, flush_o=0, mem_stall_o=1, cnt<=cnt-1, stay in MSTALL.
- cnt==0 (release cycle):
  - The access completes.
  - Outputs follow RUN priority with the memory-stall term masked; branch and load-use apply normally.
  - mem_stall_o=0, next state RUN.
  - mem_req_i in this cycle refers to the completing access and must not retrigger.
- Each access therefore produces exactly MEM_WAIT stall cycles, then one release cycle.
- Back-to-back memory instructions: the next one arrives in EX/MEM after the release edge and is detected in RUN, so the stalls repeat with no gap cycle.
- MEM_WAIT=1: enter MSTALL with cnt=0, release on the next cycle.
- MEM_WAIT=0: MSTALL is unreachable and mem_req_i has no effect.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt_o (32-bit): increments on every cycle with mem_stall_o=1 or with the load-use hold active.
  - flush_cnt_o (32-bit): increments on every branch-flush cycle.
- Both counters clear on rst and wrap modulo 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs 1 -> load_o=5'b00000, flush_o=4'b1111. First cycle after rst=0 with inputs 0 -> load_o=5'b11111, flush_o=0.
- Memory stall, MEM_WAIT=2: mem_req_i=1 at cycle t -> mem_stall_o=1 and load_o=0 at t and t+1. At t+2, load_o=5'b11111 and mem_stall_o=0. At t+3 with mem_req_i=0, no stall.
- Load-use: load_use_i=1 for one cycle -> load_o=5'b11100, flush_o=4'b0010. Next cycle with load_use_i=0 -> load_o=5'b11111.
- Branch plus load-use together -> load_o=5'b11111, flush_o=4'b0011.
- Branch during stall: mem_req_i=1 and branch_taken_i=1 held 3 cycles, MEM_WAIT=2 -> 2 stall cycles with flush_o=0, then release cycle with flush_o=4'b0011.
- Reset mid-stall, MEM_WAIT=3: rst=1 on the second stall cycle, then mem_req_i=0 -> RUN with load_o=5'b11111 in the first cycle after reset. With PIPE_CTRL_PERF_EN defined, stall_cnt_o=0 after the reset.
